dd_scan_capture: RTL and testbench

- Receiving end of the board's multiplexed 7-segment display interface: samples the scanned gate/segment lines and rebuilds the displayed hex value of every digit.
- Publishes a complete frame snapshot once all digits have been seen.
- Used in the board-level bench and on-chip as a display self-check monitor.

---
 rtl/dd_scan_capture_pkg.sv | 23 ++
 rtl/dd_scan_capture_decoder.sv | 22 ++
 rtl/dd_scan_capture.sv | 164 ++++++++++++++++
 tb/tb_dd_scan_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dd_scan_capture_pkg.sv
// Shared types and glyph table for the 7-segment scan capture block.
// The glyph table is stored active-high in gfedcba order, with dp (bit 7) always 0.
package DDScanTypes;

    typedef logic [3:0] DigitIndex;
    typedef logic [7:0] SegPattern;
    typedef logic [3:0] HexDigit;

    typedef enum logic {
        COLLECT,
        FULL
    } FrameState;

    localparam SegPattern SEG_IDLE = 8'hFF;

    localparam SegPattern SEG_GLYPH [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/dd_scan_capture_decoder.sv
// Reverse lookup of an active-high gfedcba segment pattern into a hex digit.
// Patterns that match no glyph decode to value 0 with known low.
module dd_seg_decoder
    import DDScanTypes::*;
(
    input  logic [6:0] pattern,
    output logic       known,
    output logic [3:0] hex
);

    always_comb begin
        known = 1'b0;
        hex   = 4'h0;
        for (int g = 0; g < 16; g++) begin
            if (SEG_GLYPH[g][6:0] == pattern) begin
                known = 1'b1;
                hex   = HexDigit'(g);
            end
        end
    end

endmodule

// File: rtl/dd_scan_capture.sv
// Samples a multiplexed 7-segment display bus and rebuilds the shown hex value of each digit,
// publishing a full-frame snapshot over a valid/ready handshake once every digit has been seen.
module dd_scan_capture
    import DDScanTypes::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SEG_WIDTH     = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   gate_i,
    input  logic [SEG_WIDTH-1:0]    seg_i,
    output logic [NUM_DIGITS*4-1:0] frame_digit_o,
    output logic [NUM_DIGITS-1:0]   frame_dp_o,
    output logic [NUM_DIGITS-1:0]   frame_known_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic                    overrun_o,
    output logic                    err_multi_o
);

    localparam logic [SEG_WIDTH-1:0] SEG_RESET = SEG_WIDTH'(SEG_IDLE);
    localparam logic [3:0]           CNT_LAST  = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0]           CNT_MAX   = 4'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   gate_meta;
    logic [NUM_DIGITS-1:0]   gate_s;
    logic [NUM_DIGITS-1:0]   gate_prev;
    logic [SEG_WIDTH-1:0]    seg_meta;
    logic [SEG_WIDTH-1:0]    seg_s;
    logic [SEG_WIDTH-1:0]    seg_prev;

    logic [3:0]              cnt;
    logic                    same;
    logic                    strobe;

    logic [7:0]              low_count;
    logic                    one_low;
    logic                    multi_low;
    logic [NUM_DIGITS-1:0]   cap_mask;

    logic                    glyph_known;
    logic [3:0]              glyph_hex;

    logic [NUM_DIGITS*4-1:0] work_digit;
    logic [NUM_DIGITS-1:0]   work_dp;
    logic [NUM_DIGITS-1:0]   work_known;
    logic [NUM_DIGITS-1:0]   seen;
    FrameState               state;

    // Two-flop synchronizer plus one delayed copy for change detection; idle is all lines high.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_meta <= '1;
            gate_s    <= '1;
            gate_prev <= '1;
            seg_meta  <= SEG_RESET;
            seg_s     <= SEG_RESET;
            seg_prev  <= SEG_RESET;
        end else begin
            gate_meta <= gate_i;
            gate_s    <= gate_meta;
            gate_prev <= gate_s;
            seg_meta  <= seg_i;
            seg_s     <= seg_meta;
            seg_prev  <= seg_s;
        end
    end

    assign same   = (gate_s == gate_prev) && (seg_s == seg_prev);
    assign strobe = same && (cnt == CNT_LAST);

    // Saturating at STABLE_CYCLES keeps the strobe to a single cycle per stable pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (!same) begin
            cnt <= 4'd0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        low_count = 8'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!gate_s[i]) begin
                low_count = low_count + 8'd1;
            end
        end
    end

    assign one_low   = (low_count == 8'd1);
    assign multi_low = (low_count > 8'd1);
    assign cap_mask  = (strobe && one_low) ? ~gate_s : '0;

    dd_seg_decoder u_decoder (
        .pattern (~seg_s[6:0]),
        .known   (glyph_known),
        .hex     (glyph_hex)
    );

    // Working copy of each digit; a repeat capture before frame completion simply overwrites.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_digit <= '0;
            work_dp    <= '0;
            work_known <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    work_digit[4*i +: 4] <= glyph_hex;
                    work_dp[i]           <= ~seg_s[7];
                    work_known[i]        <= glyph_known;
                end
            end
        end
    end

    // A capture landing in the FULL cycle belongs to the next frame, hence seen <= cap_mask there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            seen          <= '0;
            frame_digit_o <= '0;
            frame_dp_o    <= '0;
            frame_known_o <= '0;
            frame_valid_o <= 1'b0;
            overrun_o     <= 1'b0;
            err_multi_o   <= 1'b0;
        end else begin
            if (strobe && multi_low) begin
                err_multi_o <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    seen <= seen | cap_mask;
                    if (seen == '1) begin
                        state <= FULL;
                    end
                    if (frame_valid_o && frame_ready_i) begin
                        frame_valid_o <= 1'b0;
                    end
                end
                FULL: begin
                    frame_digit_o <= work_digit;
                    frame_dp_o    <= work_dp;
                    frame_known_o <= work_known;
                    seen          <= cap_mask;
                    if (frame_valid_o && !frame_ready_i) begin
                        overrun_o <= 1'b1;
                    end
                    frame_valid_o <= 1'b1;
                    state         <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dd_scan_capture.sv
// Directed bench for dd_scan_capture: frame rebuild, glitch/illegal glyph handling, overrun,
// multi-gate error, reset mid-frame and capture latency for STABLE_CYCLES of 4 and 1.
module tb_dd_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gate;
    logic [7:0]  seg;
    logic        ready;

    logic [15:0] frame_digit;
    logic [3:0]  frame_dp;
    logic [3:0]  frame_known;
    logic        frame_valid;
    logic        overrun;
    logic        err_multi;

    logic [15:0] fast_digit;
    logic [3:0]  fast_dp;
    logic [3:0]  fast_known;
    logic        fast_valid;
    logic        fast_overrun;
    logic        fast_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dd_scan_capture #(.NUM_DIGITS(4), .SEG_WIDTH(8), .STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .gate_i        (gate),
        .seg_i         (seg),
        .frame_digit_o (frame_digit),
        .frame_dp_o    (frame_dp),
        .frame_known_o (frame_known),
        .frame_valid_o (frame_valid),
        .frame_ready_i (ready),
        .overrun_o     (overrun),
        .err_multi_o   (err_multi)
    );

    dd_scan_capture #(.NUM_DIGITS(4), .SEG_WIDTH(8), .STABLE_CYCLES(1)) dut_fast (
        .clk           (clk),
        .rst           (rst),
        .gate_i        (gate),
        .seg_i         (seg),
        .frame_digit_o (fast_digit),
        .frame_dp_o    (fast_dp),
        .frame_known_o (fast_known),
        .frame_valid_o (fast_valid),
        .frame_ready_i (ready),
        .overrun_o     (fast_overrun),
        .err_multi_o   (fast_err)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge and are held for the given number of rising edges.
    task automatic apply_stimulus(input logic [3:0] g, input logic [7:0] s, input int cycles);
        gate = g;
        seg  = s;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        gate  = 4'hF;
        seg   = 8'hFF;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_output("reset_digit", frame_digit, 16'h0000);
        check_output("reset_dp", frame_dp, 4'h0);
        check_output("reset_known", frame_known, 4'h0);
        check_output("reset_valid", frame_valid, 1'b0);
        check_output("reset_overrun", overrun, 1'b0);
        check_output("reset_err", err_multi, 1'b0);

        // "1234" scanned digit 0..3
        apply_stimulus(4'b1110, 8'hF9, 8);
        apply_stimulus(4'b1101, 8'hA4, 8);
        apply_stimulus(4'b1011, 8'hB0, 8);
        apply_stimulus(4'b0111, 8'h99, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("f1_valid", frame_valid, 1'b1);
        check_output("f1_digit", frame_digit, 16'h4321);
        check_output("f1_known", frame_known, 4'b1111);
        check_output("f1_dp", frame_dp, 4'b0000);
        check_output("f1_overrun", overrun, 1'b0);

        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_output("accept1_valid", frame_valid, 1'b0);
        check_output("accept1_overrun", overrun, 1'b0);

        // dp-only digit 0, digit 1 = 6 with a short glitch to 8, illegal glyph on digit 2, digit 3 = A
        apply_stimulus(4'b1110, 8'h7F, 8);
        apply_stimulus(4'b1101, 8'h82, 8);
        apply_stimulus(4'b1101, 8'h80, 3);
        apply_stimulus(4'b1011, 8'hFE, 8);
        apply_stimulus(4'b0111, 8'h88, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("f2_valid", frame_valid, 1'b1);
        check_output("f2_digit", frame_digit, 16'hA060);
        check_output("f2_known", frame_known, 4'b1010);
        check_output("f2_dp", frame_dp, 4'b0001);
        check_output("f2_overrun", overrun, 1'b0);

        // "5678" completes while frame 2 is still unaccepted
        apply_stimulus(4'b1110, 8'h92, 8);
        apply_stimulus(4'b1101, 8'h82, 8);
        apply_stimulus(4'b1011, 8'hF8, 8);
        apply_stimulus(4'b0111, 8'h80, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("f3_valid", frame_valid, 1'b1);
        check_output("f3_overrun", overrun, 1'b1);
        check_output("f3_digit", frame_digit, 16'h8765);
        check_output("f3_known", frame_known, 4'b1111);
        check_output("f3_dp", frame_dp, 4'b0000);

        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check_output("accept3_valid", frame_valid, 1'b0);
        check_output("accept3_overrun", overrun, 1'b1);

        // two gates low: error flagged, and digits 0/1 must not count as seen
        apply_stimulus(4'b1100, 8'hF9, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("multi_err", err_multi, 1'b1);
        apply_stimulus(4'b1011, 8'hB0, 8);
        apply_stimulus(4'b0111, 8'h99, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("multi_no_frame", frame_valid, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst2_digit", frame_digit, 16'h0000);
        check_output("rst2_dp", frame_dp, 4'h0);
        check_output("rst2_known", frame_known, 4'h0);
        check_output("rst2_valid", frame_valid, 1'b0);
        check_output("rst2_overrun", overrun, 1'b0);
        check_output("rst2_err", err_multi, 1'b0);

        apply_stimulus(4'b1110, 8'hF9, 8);
        apply_stimulus(4'b1101, 8'hA4, 8);
        apply_stimulus(4'b1111, 8'hFF, 4);
        check_output("rst2_partial", frame_valid, 1'b0);

        // latency: last digit first sampled at edge k; valid rises at edge k+STABLE_CYCLES+4
        apply_stimulus(4'b1110, 8'hF9, 8);
        apply_stimulus(4'b1101, 8'hA4, 8);
        apply_stimulus(4'b1011, 8'hB0, 8);
        gate = 4'b0111;
        seg  = 8'h99;
        repeat (5) @(negedge clk);
        check_output("lat1_before", fast_valid, 1'b0);
        @(negedge clk);
        check_output("lat1_at", fast_valid, 1'b1);
        repeat (2) @(negedge clk);
        check_output("lat4_before", frame_valid, 1'b0);
        @(negedge clk);
        check_output("lat4_at", frame_valid, 1'b1);
        check_output("lat4_digit", frame_digit, 16'h4321);
        check_output("lat1_digit", fast_digit, 16'h4321);
        check_output("lat1_known", fast_known, 4'b1111);
        apply_stimulus(4'b1111, 8'hFF, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
